// File: rtl/instr_ram_wb.sv
// instr_ram_wb: word RAM with a Wishbone load/readback port and a 1-cycle read-only fetch port.
module instr_ram_wb #(
   parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
   parameter int          ADDR_WIDTH = 10,
   parameter bit          INIT_ZERO  = 1'b1
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic [31:0] instr_rdata_o,
   output logic        instr_rvalid_o
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [31:0] WIN_MASK = ~(32'(DEPTH * 4) - 32'd1);
   logic [31:0] mem [DEPTH] = '{default: (INIT_ZERO ? 32'h0 : 32'hx)};
   logic [ADDR_WIDTH-1:0] wb_idx, fetch_idx;
   logic hit, txn, unused_bits;
   assign wb_idx    = wbs_adr_i[ADDR_WIDTH+1:2];
   assign fetch_idx = instr_addr_i[ADDR_WIDTH+1:2];
   assign hit       = (wbs_adr_i & WIN_MASK) == BASE_ADDR;
   // the !ack term forces a one-cycle gap between back-to-back acks
   assign txn       = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
   assign unused_bits = ^{wbs_adr_i[1:0], instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};
   always_ff @(posedge clk_i) begin
      if (txn && wbs_we_i)
         for (int n = 0; n < 4; n++)
            if (wbs_sel_i[n]) mem[wb_idx][8*n +: 8] <= wbs_dat_i[8*n +: 8];
   end
   // fetch reads the pre-write word when both ports hit the same index
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wbs_ack_o      <= 1'b0;
         wbs_dat_o      <= '0;
         instr_rvalid_o <= 1'b0;
         instr_rdata_o  <= '0;
      end else begin
         wbs_ack_o      <= txn;
         wbs_dat_o      <= (txn && !wbs_we_i) ? mem[wb_idx] : '0;
         instr_rvalid_o <= instr_req_i;
         if (instr_req_i) instr_rdata_o <= mem[fetch_idx];
      end
   end
endmodule

// File: tb/tb_instr_ram_wb.sv
// tb_instr_ram_wb: directed checks of Wishbone access, byte lanes, window decode and fetch port.
module tb_instr_ram_wb;
   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int AW = 10;
   logic clk_i = 1'b0, rstn_i = 1'b0;
   logic wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
   logic [3:0] wbs_sel_i = '0;
   logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o, instr_addr_i = '0, instr_rdata_o;
   logic wbs_ack_o, instr_req_i = 0, instr_rvalid_o;
   int checks = 0, errors = 0;
   logic [31:0] rd;
   int lat;
   instr_ram_wb #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .INIT_ZERO(1'b1)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
      .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
      .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o), .instr_req_i(instr_req_i),
      .instr_addr_i(instr_addr_i), .instr_rdata_o(instr_rdata_o), .instr_rvalid_o(instr_rvalid_o)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   // single transaction; lat = cycles from strobe to ack, -1 if none within 16
   task automatic wb(input logic we, input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat,
                     output logic [31:0] rdat, output int l);
      @(posedge clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we; wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = dat;
      l = -1; rdat = 'x;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk_i); #1;
         if (wbs_ack_o) begin l = i; rdat = wbs_dat_o; break; end
      end
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = '0;
   endtask
   task automatic fetch(input string tag, input logic [31:0] adr, input logic [31:0] exp);
      @(posedge clk_i); #1;
      instr_req_i = 1; instr_addr_i = adr;
      @(posedge clk_i); #1;
      instr_req_i = 0;
      chk({tag, "_rvalid"}, 32'(instr_rvalid_o), 32'd1);
      chk({tag, "_rdata"}, instr_rdata_o, exp);
   endtask
   initial begin
      #12;
      chk("rst_ack", 32'(wbs_ack_o), 0);
      chk("rst_dat", wbs_dat_o, 0);
      chk("rst_rvalid", 32'(instr_rvalid_o), 0);
      chk("rst_rdata", instr_rdata_o, 0);
      rstn_i = 1;
      wb(1, 4'hF, BASE, 32'hDEADBEEF, rd, lat);
      chk("t1_wr_lat", 32'(lat), 1);
      chk("t1_wr_dat", rd, 0);
      @(posedge clk_i); #1;
      chk("t1_ack_drop", 32'(wbs_ack_o), 0);
      wb(0, 4'hF, BASE, 0, rd, lat);
      chk("t1_rd_lat", 32'(lat), 1);
      chk("t1_rd", rd, 32'hDEADBEEF);
      wb(1, 4'hF, BASE + 4, 32'h11223344, rd, lat);
      wb(1, 4'b0010, BASE + 4, 32'h0000AB00, rd, lat);
      chk("t2_wr_lat", 32'(lat), 1);
      wb(0, 4'hF, BASE + 4, 0, rd, lat);
      chk("t2_rd", rd, 32'h1122AB44);
      wb(1, 4'b0000, BASE + 4, 32'hFFFFFFFF, rd, lat);
      chk("sel0_lat", 32'(lat), 1);
      wb(0, 4'hF, BASE + 4, 0, rd, lat);
      chk("sel0_rd", rd, 32'h1122AB44);
      wb(1, 4'hF, BASE + 4 * (2 ** AW - 1), 32'hCAFEF00D, rd, lat);
      fetch("t3", 4 * (2 ** AW - 1), 32'hCAFEF00D);
      @(posedge clk_i); #1;
      chk("idle_rvalid", 32'(instr_rvalid_o), 0);
      chk("idle_hold", instr_rdata_o, 32'hCAFEF00D);
      wb(0, 4'hF, BASE + 2 ** (AW + 2), 0, rd, lat);
      chk("t4_rd_noack", 32'(lat), 32'hFFFFFFFF);
      wb(1, 4'hF, BASE + 2 ** (AW + 2), 32'h0, rd, lat);
      chk("t4_wr_noack", 32'(lat), 32'hFFFFFFFF);
      wb(1, 4'hF, 32'h2000_0000, 32'h0, rd, lat);
      chk("t4_far_noack", 32'(lat), 32'hFFFFFFFF);
      wb(0, 4'hF, BASE, 0, rd, lat);
      chk("t4_unchanged", rd, 32'hDEADBEEF);
      // back-to-back fetches on consecutive cycles
      @(posedge clk_i); #1;
      instr_req_i = 1; instr_addr_i = 0;
      @(posedge clk_i); #1;
      chk("b2b0", instr_rdata_o, 32'hDEADBEEF);
      instr_addr_i = 32'h0000_1004;
      @(posedge clk_i); #1;
      chk("b2b1_wrap", instr_rdata_o, 32'h1122AB44);
      chk("b2b1_rvalid", 32'(instr_rvalid_o), 1);
      instr_req_i = 0;
      wb(1, 4'hF, BASE + 12, 32'hFFFFFFFF, rd, lat);
      @(posedge clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = BASE + 12; wbs_dat_i = 32'h1;
      instr_req_i = 1; instr_addr_i = 12;
      @(posedge clk_i); #1;
      wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; instr_req_i = 0;
      chk("t5_ack", 32'(wbs_ack_o), 1);
      chk("t5_old", instr_rdata_o, 32'hFFFFFFFF);
      fetch("t5_new", 12, 32'h1);
      // strobe held: ack pattern 1,0,1 with data zero in the gap
      @(posedge clk_i); #1;
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_sel_i = 4'hF; wbs_adr_i = BASE + 4;
      @(posedge clk_i); #1;
      chk("hold_ack1", 32'(wbs_ack_o), 1);
      chk("hold_dat1", wbs_dat_o, 32'h1122AB44);
      @(posedge clk_i); #1;
      chk("hold_gap", 32'(wbs_ack_o), 0);
      chk("hold_gap_dat", wbs_dat_o, 0);
      @(posedge clk_i); #1;
      chk("hold_ack2", 32'(wbs_ack_o), 1);
      instr_req_i = 1; instr_addr_i = 0;
      @(posedge clk_i); #1;
      chk("pre_rst_rvalid", 32'(instr_rvalid_o), 1);
      rstn_i = 0;
      #1;
      chk("async_ack", 32'(wbs_ack_o), 0);
      chk("async_rvalid", 32'(instr_rvalid_o), 0);
      chk("async_rdata", instr_rdata_o, 0);
      wbs_cyc_i = 0; wbs_stb_i = 0; instr_req_i = 0;
      @(posedge clk_i); #1;
      rstn_i = 1;
      wb(0, 4'hF, BASE, 0, rd, lat);
      chk("post_rst_keep", rd, 32'hDEADBEEF);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
